// File: rtl/pipeline_pkg.sv
// Shared pipeline encodings: ALU operation selects, branch opcodes and REGIMM rt codes.
package pipeline_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_NOR   = 4'b0101,
    ALU_SLL   = 4'b0110,
    ALU_SRL   = 4'b0111,
    ALU_SRA   = 4'b1000,
    ALU_SLT   = 4'b1001,
    ALU_SLTU  = 4'b1010,
    ALU_PASSA = 4'b1011,
    ALU_PASSB = 4'b1100
  } alu_op_e;

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

endpackage

// File: rtl/ex_cond_eval.sv
// Branch condition evaluation from opcode/rt and the same-cycle ALU Z/N flags.
module ex_cond_eval
  import pipeline_pkg::*;
(
  input  logic       b_instr,
  input  logic [5:0] opcode,
  input  logic [4:0] rt,
  input  logic       z,
  input  logic       n,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    if (b_instr) begin
      unique case (opcode)
        OP_BEQ:    taken = z;
        OP_BNE:    taken = !z;
        OP_BLEZ:   taken = z | n;
        OP_BGTZ:   taken = !z & !n;
        OP_REGIMM: begin
          if (rt == RT_BLTZ || rt == RT_BLTZAL)      taken = n;
          else if (rt == RT_BGEZ || rt == RT_BGEZAL) taken = !n;
          else                                       taken = 1'b0;
        end
        default:   taken = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/ex_alu_branch_unit.sv
// Execute stage: 32-bit ALU, PC+4 incrementer and branch resolution.
// Only state is flags_q, the previous cycle's {N,Z}, kept for debug/trace.
module ex_alu_branch_unit
  import pipeline_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    alu_op,
  input  logic [DW-1:0] alu_a,
  input  logic [DW-1:0] alu_b,
  output logic [DW-1:0] alu_out,
  output logic          alu_z,
  output logic          alu_n,
  input  logic [DW-1:0] pc_in,
  output logic [DW-1:0] pc_plus4,
  input  logic          b_instr,
  input  logic [5:0]    opcode,
  input  logic [4:0]    rt,
  output logic          branch_taken,
  output logic [1:0]    flags_q
);

  logic [4:0] shamt;
  logic       lt_s;
  logic       lt_u;

  assign shamt = alu_a[4:0];
  assign lt_s  = $signed(alu_a) < $signed(alu_b);
  assign lt_u  = alu_a < alu_b;

  always_comb begin
    alu_out = '0;
    case (alu_op)
      ALU_ADD:   alu_out = alu_a + alu_b;
      ALU_SUB:   alu_out = alu_a - alu_b;
      ALU_AND:   alu_out = alu_a & alu_b;
      ALU_OR:    alu_out = alu_a | alu_b;
      ALU_XOR:   alu_out = alu_a ^ alu_b;
      ALU_NOR:   alu_out = ~(alu_a | alu_b);
      ALU_SLL:   alu_out = alu_b << shamt;
      ALU_SRL:   alu_out = alu_b >> shamt;
      ALU_SRA:   alu_out = $unsigned($signed(alu_b) >>> shamt);
      ALU_SLT:   alu_out = {{(DW-1){1'b0}}, lt_s};
      ALU_SLTU:  alu_out = {{(DW-1){1'b0}}, lt_u};
      ALU_PASSA: alu_out = alu_a;
      ALU_PASSB: alu_out = alu_b;
      default:   alu_out = '0;
    endcase
  end

  assign alu_z    = (alu_out == '0);
  assign alu_n    = alu_out[DW-1];
  assign pc_plus4 = pc_in + DW'(4);

  ex_cond_eval u_cond (
    .b_instr (b_instr),
    .opcode  (opcode),
    .rt      (rt),
    .z       (alu_z),
    .n       (alu_n),
    .taken   (branch_taken)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) flags_q <= '0;
    else        flags_q <= {alu_n, alu_z};
  end

endmodule

// File: tb/tb_ex_alu_branch_unit.sv
// Directed bench for ex_alu_branch_unit: vector table plus reset/flag sequences.
module tb_ex_alu_branch_unit;

  logic        clk;
  logic        reset;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;
  logic        alu_z;
  logic        alu_n;
  logic [31:0] pc_in;
  logic [31:0] pc_plus4;
  logic        b_instr;
  logic [5:0]  opcode;
  logic [4:0]  rt;
  logic        branch_taken;
  logic [1:0]  flags_q;

  int unsigned n_tests;
  int unsigned n_fail;

  ex_alu_branch_unit #(.DW(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_op       (alu_op),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_out      (alu_out),
    .alu_z        (alu_z),
    .alu_n        (alu_n),
    .pc_in        (pc_in),
    .pc_plus4     (pc_plus4),
    .b_instr      (b_instr),
    .opcode       (opcode),
    .rt           (rt),
    .branch_taken (branch_taken),
    .flags_q      (flags_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic        bi;
    logic [5:0]  opc;
    logic [4:0]  rt;
    logic [31:0] y;
    logic        z;
    logic        n;
    logic [31:0] pcx;
    logic        tk;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, logic [3:0] op, logic [31:0] a, logic [31:0] b,
                              logic [31:0] pc, logic bi, logic [5:0] opc, logic [4:0] rtv,
                              logic [31:0] y, logic z, logic n, logic [31:0] pcx, logic tk);
    vec_t v;
    v.nm = nm; v.op = op; v.a = a; v.b = b; v.pc = pc; v.bi = bi; v.opc = opc; v.rt = rtv;
    v.y = y; v.z = z; v.n = n; v.pcx = pcx; v.tk = tk;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    alu_op  = 4'b0000;
    alu_a   = '0;
    alu_b   = '0;
    pc_in   = '0;
    b_instr = 1'b0;
    opcode  = '0;
    rt      = '0;

    //          name          op     A             B             pc            bi   opcode     rt         y             z     n     pc+4          taken
    vecs.push_back(mk("add_wrap",  4'h0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0010, 1'b0, 6'b000100, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 32'h0000_0014, 1'b0));
    vecs.push_back(mk("sub_wrap",  4'h1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFC, 1'b1, 6'b000110, 5'd0,  32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_0000, 1'b1));
    vecs.push_back(mk("slt",       4'h9, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 6'b000100, 5'd0,  32'h0000_0001, 1'b0, 1'b0, 32'h0000_0004, 1'b0));
    vecs.push_back(mk("sltu",      4'hA, 32'hFFFF_FFFF, 32'h0000_0001, 32'h1234_5678, 1'b1, 6'b000100, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 32'h1234_567C, 1'b1));
    vecs.push_back(mk("slt_pos",   4'h9, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 6'b000000, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 32'h0000_0004, 1'b0));
    vecs.push_back(mk("sra",       4'h8, 32'h0000_0004, 32'h8000_0000, 32'h0000_0000, 1'b1, 6'b000001, 5'd0,  32'hF800_0000, 1'b0, 1'b1, 32'h0000_0004, 1'b1));
    vecs.push_back(mk("srl",       4'h7, 32'h0000_0004, 32'h8000_0000, 32'h0000_0000, 1'b0, 6'b000000, 5'd0,  32'h0800_0000, 1'b0, 1'b0, 32'h0000_0004, 1'b0));
    vecs.push_back(mk("sll_shamt", 4'h6, 32'h0000_0024, 32'h0000_0003, 32'h0000_0000, 1'b0, 6'b000000, 5'd0,  32'h0000_0030, 1'b0, 1'b0, 32'h0000_0004, 1'b0));
    vecs.push_back(mk("and",       4'h2, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h0000_0000, 1'b1, 6'b000101, 5'd0,  32'h00F0_000F, 1'b0, 1'b0, 32'h0000_0004, 1'b1));
    vecs.push_back(mk("or",        4'h3, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h0000_0000, 1'b0, 6'b000000, 5'd0,  32'hFFF0_0FFF, 1'b0, 1'b1, 32'h0000_0004, 1'b0));
    vecs.push_back(mk("xor",       4'h4, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h0000_0000, 1'b0, 6'b000000, 5'd0,  32'hFF00_0FF0, 1'b0, 1'b1, 32'h0000_0004, 1'b0));
    vecs.push_back(mk("nor",       4'h5, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h0000_0000, 1'b0, 6'b000000, 5'd0,  32'h000F_F000, 1'b0, 1'b0, 32'h0000_0004, 1'b0));
    vecs.push_back(mk("passb",     4'hC, 32'h0000_0001, 32'h1234_5678, 32'h0000_0000, 1'b0, 6'b000000, 5'd0,  32'h1234_5678, 1'b0, 1'b0, 32'h0000_0004, 1'b0));
    vecs.push_back(mk("bgtz_pos",  4'hB, 32'h0000_0003, 32'h0000_0000, 32'h0000_0000, 1'b1, 6'b000111, 5'd0,  32'h0000_0003, 1'b0, 1'b0, 32'h0000_0004, 1'b1));
    vecs.push_back(mk("bgtz_zero", 4'hB, 32'h0000_0000, 32'h0000_0009, 32'h0000_0000, 1'b1, 6'b000111, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 32'h0000_0004, 1'b0));
    vecs.push_back(mk("bgtz_nobi", 4'hB, 32'h0000_0003, 32'h0000_0000, 32'h0000_0000, 1'b0, 6'b000111, 5'd0,  32'h0000_0003, 1'b0, 1'b0, 32'h0000_0004, 1'b0));
    vecs.push_back(mk("bne_eq",    4'h1, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b1, 6'b000101, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 32'h0000_0004, 1'b0));
    vecs.push_back(mk("bne_ne",    4'h1, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 1'b1, 6'b000101, 5'd0,  32'h0000_0002, 1'b0, 1'b0, 32'h0000_0004, 1'b1));
    vecs.push_back(mk("beq_nobi",  4'h1, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b0, 6'b000100, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 32'h0000_0004, 1'b0));
    vecs.push_back(mk("bgez_neg",  4'hB, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 6'b000001, 5'd1,  32'h8000_0000, 1'b0, 1'b1, 32'h0000_0004, 1'b0));
    vecs.push_back(mk("bgezal",    4'hB, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b1, 6'b000001, 5'd17, 32'h0000_0005, 1'b0, 1'b0, 32'h0000_0004, 1'b1));
    vecs.push_back(mk("bltzal",    4'hB, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b1, 6'b000001, 5'd16, 32'h0000_0005, 1'b0, 1'b0, 32'h0000_0004, 1'b0));
    vecs.push_back(mk("rt_bad",    4'hB, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 6'b000001, 5'd3,  32'h8000_0000, 1'b0, 1'b1, 32'h0000_0004, 1'b0));
    vecs.push_back(mk("op_unused", 4'hE, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_0000, 1'b1, 6'b001001, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 32'h0000_0004, 1'b0));
    vecs.push_back(mk("op_f",      4'hF, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_0000, 1'b1, 6'b000100, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 32'h0000_0004, 1'b1));

    // Reset state, and combinational outputs tracking while reset is held.
    #3;
    chk("reset_flags", 32'(flags_q), 32'h0);
    alu_op = 4'h0; alu_a = 32'h0000_0002; alu_b = 32'h0000_0003;
    #1;
    chk("reset_comb_add", alu_out, 32'h0000_0005);

    // Release, then flags follow the previous cycle's {N,Z}.
    @(negedge clk);
    reset = 1'b1;
    alu_op = 4'h1; alu_a = 32'd5; alu_b = 32'd5;
    #1;
    chk("sub_eq_out", alu_out, 32'h0);
    chk("sub_eq_z", 32'(alu_z), 32'h1);
    chk("sub_eq_n", 32'(alu_n), 32'h0);
    @(posedge clk); #1;
    chk("flags_z", 32'(flags_q), 32'h1);
    alu_a = 32'd0; alu_b = 32'd1;
    @(posedge clk); #1;
    chk("flags_n", 32'(flags_q), 32'h2);

    // Asynchronous mid-cycle reset clears flags without a clock edge.
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_flags", 32'(flags_q), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      alu_op  = vecs[i].op;
      alu_a   = vecs[i].a;
      alu_b   = vecs[i].b;
      pc_in   = vecs[i].pc;
      b_instr = vecs[i].bi;
      opcode  = vecs[i].opc;
      rt      = vecs[i].rt;
      #1;
      chk({vecs[i].nm, ".out"},   alu_out,             vecs[i].y);
      chk({vecs[i].nm, ".z"},     32'(alu_z),          32'(vecs[i].z));
      chk({vecs[i].nm, ".n"},     32'(alu_n),          32'(vecs[i].n));
      chk({vecs[i].nm, ".pc4"},   pc_plus4,            vecs[i].pcx);
      chk({vecs[i].nm, ".taken"}, 32'(branch_taken),   32'(vecs[i].tk));
    end

    // Flag register captures the last vector's outputs (op_f: Z=1, N=0).
    @(posedge clk); #1;
    chk("flags_last", 32'(flags_q), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
